ysyx_22051468_pc_gen: RTL and testbench

Program-counter generator for the NPC front end. Holds the architectural fetch PC, presents it to the IF stage over a valid/ready handshake, and advances it sequentially by 4. When the EX-stage branch unit resolves a taken branch or jump, it redirects to the resolved target. A redirect that arrives while IF is stalled is buffered, and the stale fetch is tagged for discard.

---
 rtl/ysyx_22051468_pkg.sv | 17 +
 rtl/ysyx_22051468_pc_gen.sv | 139 +++++++++++++
 tb/tb_ysyx_22051468_pc_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22051468_pkg.sv
// ysyx_22051468_pkg
// Shared types and constants for the NPC front-end PC generator.
//   pcg_state_e      : PC generator FSM states (BOOT/RUN/HOLD)
//   INST_BYTES       : sequential fetch stride
//   DEFAULT_RESET_PC : first fetch address after reset
package ysyx_22051468_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pcg_state_e;

  localparam int unsigned INST_BYTES       = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22051468_pc_gen.sv
// ysyx_22051468_pc_gen
// Program-counter generator for the NPC front end. Presents the fetch PC to
// IF over a valid/ready handshake, advances it by 4 per accepted fetch, and
// redirects on a taken branch/jump resolved in EX. A redirect that arrives
// while IF is stalled is parked in r_pending and the stalled fetch is killed
// when it finally hands off.
//
// Optional feature macro: YSYX_22051468_MISALIGN_TRAP_EN
//   defined   : misaligned redirect targets raise trap_o/trap_tval_o instead
//               of redirecting
//   undefined : target bits [1:0] are cleared, trap outputs tied to 0
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   br_taken_i, jump_i  EX branch taken / unconditional jump
//   ex_valid_i          EX instruction is valid
//   target_i            resolved redirect target
//   if_ready_i          IF accepts pc_o this cycle
//   pc_o, pc_valid_o    fetch PC and its valid
//   flush_o             registered one-cycle flush pulse
//   kill_o              combinational: current handshake fetches wrong path
//   trap_o, trap_tval_o misaligned-target trap pulse and offending target
//
// state | meaning
// BOOT  | reset, no valid PC yet
// RUN   | normal sequential fetch, redirects applied directly
// HOLD  | redirect parked, waiting for the stalled fetch to hand off
module ysyx_22051468_pc_gen
  import ysyx_22051468_pkg::*;
#(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_taken_i,
  input  logic             jump_i,
  input  logic             ex_valid_i,
  input  logic [WIDTH-1:0] target_i,
  input  logic             if_ready_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid_o,
  output logic             flush_o,
  output logic             kill_o,
  output logic             trap_o,
  output logic [WIDTH-1:0] trap_tval_o
);

  pcg_state_e       r_state;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_pending;
  logic             r_pc_valid;
  logic             r_flush;

  logic             w_req;
  logic             w_hs;
  logic             w_misalign;
  logic             w_redirect;
  logic [WIDTH-1:0] w_target;

  assign w_req    = ex_valid_i & (br_taken_i | jump_i);
  assign w_hs     = r_pc_valid & if_ready_i;
  assign w_target = target_i & ~{{(WIDTH-2){1'b0}}, 2'b11};

`ifdef YSYX_22051468_MISALIGN_TRAP_EN
  logic             r_trap;
  logic [WIDTH-1:0] r_tval;

  assign w_misalign  = |target_i[1:0];
  assign trap_o      = r_trap;
  assign trap_tval_o = r_tval;
`else
  assign w_misalign  = 1'b0;
  assign trap_o      = 1'b0;
  assign trap_tval_o = '0;
`endif

  // A misaligned request is treated as no request for the fetch path, so
  // a coinciding handshake still advances the PC sequentially.
  assign w_redirect = w_req & ~w_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_pending  <= '0;
      r_pc_valid <= 1'b0;
      r_flush    <= 1'b0;
`ifdef YSYX_22051468_MISALIGN_TRAP_EN
      r_trap     <= 1'b0;
      r_tval     <= '0;
`endif
    end else begin
      r_flush <= 1'b0;
`ifdef YSYX_22051468_MISALIGN_TRAP_EN
      r_trap  <= 1'b0;
`endif
      case (r_state)
        BOOT: begin
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
        end
        RUN: begin
          if (w_redirect && (!r_pc_valid || if_ready_i)) begin
            r_pc    <= w_target;
            r_flush <= 1'b1;
          end else if (w_redirect) begin
            // IF is stalled on pc_o: keep it stable, park the target
            r_pending <= w_target;
            r_flush   <= 1'b1;
            r_state   <= HOLD;
          end else if (w_hs) begin
            r_pc <= r_pc + WIDTH'(INST_BYTES);
          end
`ifdef YSYX_22051468_MISALIGN_TRAP_EN
          if (w_req && w_misalign) begin
            r_trap <= 1'b1;
            r_tval <= target_i;
          end
`endif
        end
        HOLD: begin
          // requests here come from wrong-path instructions and are ignored
          if (w_hs) begin
            r_pc    <= r_pending;
            r_state <= RUN;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign pc_o       = r_pc;
  assign pc_valid_o = r_pc_valid;
  assign flush_o    = r_flush;
  assign kill_o     = w_hs & (((r_state == RUN) & w_redirect) | (r_state == HOLD));

endmodule

// File: tb/tb_ysyx_22051468_pc_gen.sv
// tb_ysyx_22051468_pc_gen
// Directed bench for the PC generator. Inputs change 1 ns after a rising
// edge; registered outputs are sampled there, kill_o 1 ns after the inputs.
module tb_ysyx_22051468_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        br_taken_i = 1'b0;
  logic        jump_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [63:0] target_i = '0;
  logic        if_ready_i = 1'b1;
  logic [63:0] pc_o;
  logic        pc_valid_o;
  logic        flush_o;
  logic        kill_o;
  logic        trap_o;
  logic [63:0] trap_tval_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_22051468_pc_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_taken_i (br_taken_i),
    .jump_i     (jump_i),
    .ex_valid_i (ex_valid_i),
    .target_i   (target_i),
    .if_ready_i (if_ready_i),
    .pc_o       (pc_o),
    .pc_valid_o (pc_valid_o),
    .flush_o    (flush_o),
    .kill_o     (kill_o),
    .trap_o     (trap_o),
    .trap_tval_o(trap_tval_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic jmp, input logic [63:0] tgt);
    ex_valid_i = v;
    jump_i     = jmp;
    br_taken_i = v & ~jmp;
    target_i   = tgt;
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if (pc_o !== 64'h8000_0000) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 64'h8000_0000); end
    n_vec++; if (pc_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", pc_valid_o); end
    n_vec++; if (flush_o !== 1'b0) begin n_err++; $display("FAIL reset_flush got=%b exp=0", flush_o); end
    n_vec++; if (kill_o !== 1'b0) begin n_err++; $display("FAIL reset_kill got=%b exp=0", kill_o); end
    n_vec++; if (trap_o !== 1'b0 || trap_tval_o !== 64'h0) begin n_err++; $display("FAIL reset_trap got=%b/%h exp=0/0", trap_o, trap_tval_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    step();
    n_vec++; if (pc_valid_o !== 1'b1 || pc_o !== 64'h8000_0000) begin n_err++; $display("FAIL boot_first got=%b/%h exp=1/80000000", pc_valid_o, pc_o); end
    step();
    n_vec++; if (pc_o !== 64'h8000_0004) begin n_err++; $display("FAIL seq_4 got=%h exp=80000004", pc_o); end
    step();
    n_vec++; if (pc_o !== 64'h8000_0008) begin n_err++; $display("FAIL seq_8 got=%h exp=80000008", pc_o); end
    if_ready_i = 1'b0;
    step();
    n_vec++; if (pc_o !== 64'h8000_0008) begin n_err++; $display("FAIL stall_hold got=%h exp=80000008", pc_o); end
    if_ready_i = 1'b1;
  endtask

  task automatic test_redirect_run();
    drive_req(1'b1, 1'b0, 64'h8000_0100);
    #1;
    n_vec++; if (kill_o !== 1'b1) begin n_err++; $display("FAIL run_kill got=%b exp=1", kill_o); end
    step();
    drive_req(1'b0, 1'b0, 64'h0);
    n_vec++; if (pc_o !== 64'h8000_0100) begin n_err++; $display("FAIL run_target got=%h exp=80000100", pc_o); end
    n_vec++; if (flush_o !== 1'b1) begin n_err++; $display("FAIL run_flush_on got=%b exp=1", flush_o); end
    step();
    n_vec++; if (flush_o !== 1'b0) begin n_err++; $display("FAIL run_flush_off got=%b exp=0", flush_o); end
    n_vec++; if (pc_o !== 64'h8000_0104) begin n_err++; $display("FAIL run_after got=%h exp=80000104", pc_o); end
  endtask

  task automatic test_hold();
    drive_req(1'b1, 1'b1, 64'h8000_0010);
    step();
    n_vec++; if (pc_o !== 64'h8000_0010) begin n_err++; $display("FAIL hold_setup got=%h exp=80000010", pc_o); end
    if_ready_i = 1'b0;
    drive_req(1'b1, 1'b0, 64'h8000_0200);
    #1;
    n_vec++; if (kill_o !== 1'b0) begin n_err++; $display("FAIL hold_nokill got=%b exp=0", kill_o); end
    step();
    drive_req(1'b0, 1'b0, 64'h0);
    n_vec++; if (pc_o !== 64'h8000_0010 || flush_o !== 1'b1) begin n_err++; $display("FAIL hold_enter got=%h/%b exp=80000010/1", pc_o, flush_o); end
    step();
    n_vec++; if (pc_o !== 64'h8000_0010 || flush_o !== 1'b0) begin n_err++; $display("FAIL hold_stable got=%h/%b exp=80000010/0", pc_o, flush_o); end
    if_ready_i = 1'b1;
    #1;
    n_vec++; if (kill_o !== 1'b1) begin n_err++; $display("FAIL hold_kill got=%b exp=1", kill_o); end
    step();
    n_vec++; if (pc_o !== 64'h8000_0200) begin n_err++; $display("FAIL hold_target got=%h exp=80000200", pc_o); end
    n_vec++; if (kill_o !== 1'b0) begin n_err++; $display("FAIL hold_kill_off got=%b exp=0", kill_o); end
    step();
    n_vec++; if (pc_o !== 64'h8000_0204) begin n_err++; $display("FAIL hold_after got=%h exp=80000204", pc_o); end
  endtask

  task automatic test_wrap();
    drive_req(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    drive_req(1'b0, 1'b0, 64'h0);
    n_vec++; if (pc_o !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_err++; $display("FAIL wrap_setup got=%h exp=fffffffffffffffc", pc_o); end
    step();
    n_vec++; if (pc_o !== 64'h0) begin n_err++; $display("FAIL wrap_zero got=%h exp=0", pc_o); end
  endtask

  task automatic test_misalign();
    drive_req(1'b1, 1'b0, 64'h8000_0102);
`ifdef YSYX_22051468_MISALIGN_TRAP_EN
    #1;
    n_vec++; if (kill_o !== 1'b0) begin n_err++; $display("FAIL mis_kill got=%b exp=0", kill_o); end
    step();
    drive_req(1'b0, 1'b0, 64'h0);
    n_vec++; if (pc_o !== 64'h4 || flush_o !== 1'b0) begin n_err++; $display("FAIL mis_noredir got=%h/%b exp=4/0", pc_o, flush_o); end
    n_vec++; if (trap_o !== 1'b1 || trap_tval_o !== 64'h8000_0102) begin n_err++; $display("FAIL mis_trap got=%b/%h exp=1/80000102", trap_o, trap_tval_o); end
    step();
    n_vec++; if (trap_o !== 1'b0 || trap_tval_o !== 64'h8000_0102) begin n_err++; $display("FAIL mis_trap_end got=%b/%h exp=0/80000102", trap_o, trap_tval_o); end
`else
    #1;
    n_vec++; if (kill_o !== 1'b1) begin n_err++; $display("FAIL mis_kill got=%b exp=1", kill_o); end
    step();
    drive_req(1'b0, 1'b0, 64'h0);
    n_vec++; if (pc_o !== 64'h8000_0100 || flush_o !== 1'b1) begin n_err++; $display("FAIL mis_redir got=%h/%b exp=80000100/1", pc_o, flush_o); end
    n_vec++; if (trap_o !== 1'b0 || trap_tval_o !== 64'h0) begin n_err++; $display("FAIL mis_notrap got=%b/%h exp=0/0", trap_o, trap_tval_o); end
    step();
    n_vec++; if (pc_o !== 64'h8000_0104) begin n_err++; $display("FAIL mis_after got=%h exp=80000104", pc_o); end
`endif
  endtask

  task automatic test_reset_in_hold();
    if_ready_i = 1'b0;
    drive_req(1'b1, 1'b0, 64'h8000_0400);
    step();
    drive_req(1'b0, 1'b0, 64'h0);
    n_vec++; if (flush_o !== 1'b1) begin n_err++; $display("FAIL rh_flush got=%b exp=1", flush_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (pc_o !== 64'h8000_0000 || pc_valid_o !== 1'b0) begin n_err++; $display("FAIL rh_async got=%h/%b exp=80000000/0", pc_o, pc_valid_o); end
    n_vec++; if (flush_o !== 1'b0 || kill_o !== 1'b0) begin n_err++; $display("FAIL rh_clear got=%b/%b exp=0/0", flush_o, kill_o); end
    @(negedge clk);
    @(negedge clk);
    if_ready_i = 1'b1;
    rst_n = 1'b1;
    step();
    n_vec++; if (pc_o !== 64'h8000_0000 || pc_valid_o !== 1'b1) begin n_err++; $display("FAIL rh_restart got=%h/%b exp=80000000/1", pc_o, pc_valid_o); end
    step();
    n_vec++; if (pc_o !== 64'h8000_0004) begin n_err++; $display("FAIL rh_next got=%h exp=80000004", pc_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect_run();
    test_hold();
    test_wrap();
    test_misalign();
    test_reset_in_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
